// File: rtl/buf_arb_pkg.sv
// Shared types and constants for the round-robin buffer-share arbiter.
// Holds the FSM state encoding, default sizing and the index-width helper.
package buf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotated priority encode starting just
// after the last granted index, wrapping around.
module rr_pick
  import buf_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = idx_width(DEF_N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] pick
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  int             off_s;
  int             sum_s;

  // Rotate so bit 0 is requester last+1, find lowest set bit, map back.
  always_comb begin
    dbl_s = {req, req} >> (int'(last) + 1);
    rot_s = dbl_s[N-1:0];
    off_s = 0;
    for (int j = N - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? j : off_s;
    end
    sum_s = int'(last) + 1 + off_s;
    pick  = (sum_s >= N) ? IW'(sum_s - N) : IW'(sum_s);
    any   = |req;
  end

endmodule

// File: rtl/buf_share_arbiter.sv
// Shares one registered output lane among N requesters with round-robin
// grants, bounded bursts and one turnaround cycle between owners.
module buf_share_arbiter
  import buf_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   y,
  output logic           y_valid
);

  localparam int IW = idx_width(N);
  localparam int HW = idx_width(MAX_HOLD + 1);
  localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

  logic [W-1:0]  din_a [N];
  state_t        state_r, state_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic [IW-1:0] last_r, last_s, pick_s;
  logic [N-1:0]  gnt_r, gnt_s;
  logic [W-1:0]  y_r, y_s;
  logic          y_valid_r, y_valid_s;
  logic          any_s, release_s;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign din_a[i] = din[i*W +: W];
  end

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req),
    .last (last_r),
    .any  (any_s),
    .pick (pick_s)
  );

  // The owner is always last_r while granted.
  assign release_s = !req[last_r] || (hold_cnt_r == HW'(MAX_HOLD));

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_cnt_r <= {HW{1'b0}};
      last_r     <= LAST_INIT;
      gnt_r      <= {N{1'b0}};
      y_r        <= {W{1'b0}};
      y_valid_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      last_r     <= last_s;
      gnt_r      <= gnt_s;
      y_r        <= y_s;
      y_valid_r  <= y_valid_s;
    end
  end

  // Next-state decision.
  always_comb begin
    case (state_r)
      IDLE:    state_s = any_s ? GRANT : IDLE;
      GRANT:   state_s = release_s ? TURN : GRANT;
      TURN:    state_s = any_s ? GRANT : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of grant, pointer, burst counter and data lane.
  always_comb begin
    gnt_s      = gnt_r;
    hold_cnt_s = hold_cnt_r;
    last_s     = last_r;
    y_s        = y_r;
    y_valid_s  = 1'b0;
    case (state_r)
      GRANT: begin
        y_s       = din_a[last_r];
        y_valid_s = req[last_r];
        if (release_s) begin
          gnt_s      = {N{1'b0}};
          hold_cnt_s = {HW{1'b0}};
        end else begin
          hold_cnt_s = hold_cnt_r + HW'(1);
        end
      end
      IDLE, TURN: begin
        if (any_s) begin
          gnt_s      = ONE_HOT0 << pick_s;
          last_s     = pick_s;
          hold_cnt_s = HW'(1);
        end else begin
          gnt_s      = {N{1'b0}};
          hold_cnt_s = {HW{1'b0}};
        end
      end
      default: begin
        gnt_s      = {N{1'b0}};
        hold_cnt_s = {HW{1'b0}};
      end
    endcase
  end

  assign gnt     = gnt_r;
  assign y       = y_r;
  assign y_valid = y_valid_r;

endmodule

// File: tb/tb_buf_share_arbiter.sv
// Self-checking bench for buf_share_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_buf_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [W-1:0]   y;
  logic           y_valid;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  buf_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid)
  );

  // Model: current owner (-1 none), pointer, beats taken, output lane.
  typedef struct packed {
    int           owner;
    int           ptr;
    int           beats;
    logic [W-1:0] y;
    logic         yv;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.owner = -1;
    s.ptr   = N - 1;
    s.beats = 0;
    s.y     = '0;
    s.yv    = 1'b0;
    return s;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input logic [N-1:0] r,
                                     input logic [N*W-1:0] d);
    mstate_t n;
    int c;
    n = s;
    if (s.owner >= 0) begin
      n.y     = d[s.owner*W +: W];
      n.yv    = r[s.owner];
      n.beats = s.beats + 1;
      if (!r[s.owner] || n.beats == MH) begin
        n.owner = -1;
        n.beats = 0;
      end
    end else begin
      n.yv = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (s.ptr + k) % N;
        if (n.owner < 0 && r[c]) begin
          n.owner = c;
          n.ptr   = c;
          n.beats = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] m_gnt(input mstate_t s);
    logic [N-1:0] one;
    one = 1;
    return (s.owner < 0) ? '0 : (one << s.owner);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= m_reset();
    else     m <= m_step(m, req, din);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_gnt", 32'(gnt), 32'(m_gnt(m)));
      chk("model_y_valid", 32'(y_valid), 32'(m.yv));
      chk("model_y", 32'(y), 32'(m.y));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      assert ($onehot0(gnt)) else $error("gnt not one-hot-or-zero: %b", gnt);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_new_grant(output logic [N-1:0] g);
    int cnt;
    cnt = 0;
    while (gnt != '0 && cnt < 20) begin step(); cnt++; end
    while (gnt == '0 && cnt < 20) begin step(); cnt++; end
    g = gnt;
    if (cnt >= 20) chk("grant_timeout", 32'(cnt), 32'd0);
  endtask

  logic [N-1:0] g;
  logic [N-1:0] exp_g;

  initial begin
    rst = 1'b1;
    req = '0;
    din = '0;
    step();
    step();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset then idle.
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_y_valid", 32'(y_valid), 32'h0);
    chk("reset_y", 32'(y), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_y_valid", 32'(y_valid), 32'h0);
      chk("idle_y", 32'(y), 32'h0);
    end

    // Single requester: 4-cycle burst, one TURN, re-grant.
    din[7:0] = 8'hA5;
    req      = 4'b0001;
    step();
    chk("single_grant", 32'(gnt), 32'h1);
    chk("single_first_yv", 32'(y_valid), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("single_burst_gnt", 32'(gnt), 32'h1);
      chk("single_burst_yv", 32'(y_valid), 32'h1);
      chk("single_burst_y", 32'(y), 32'hA5);
    end
    step();
    chk("single_turn_gnt", 32'(gnt), 32'h0);
    chk("single_last_beat_yv", 32'(y_valid), 32'h1);
    chk("single_last_beat_y", 32'(y), 32'hA5);
    step();
    chk("single_regrant", 32'(gnt), 32'h1);
    chk("single_turn_yv", 32'(y_valid), 32'h0);
    req = '0;
    repeat (6) step();

    // All requesting from a fresh pointer.
    do_reset();
    din = {8'h40, 8'h30, 8'h20, 8'h10};
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      step();
      exp_g = ((c % 5) == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
      chk("all_rr_gnt", 32'(gnt), 32'(exp_g));
    end
    req = '0;
    repeat (6) step();

    // Early release: owner 2 drops after two edges.
    req = 4'b0100;
    step();
    chk("early_grant", 32'(gnt), 32'h4);
    step();
    chk("early_beat_yv", 32'(y_valid), 32'h1);
    chk("early_beat_y", 32'(y), 32'h30);
    req = '0;
    step();
    chk("early_release_gnt", 32'(gnt), 32'h0);
    chk("early_release_yv", 32'(y_valid), 32'h0);
    step();
    chk("early_idle_gnt", 32'(gnt), 32'h0);
    repeat (2) step();

    // Pointer fairness after a grant to requester 1.
    req = 4'b0010;
    step();
    chk("fair_first", 32'(gnt), 32'h2);
    req = '0;
    step();
    chk("fair_release", 32'(gnt), 32'h0);
    req = 4'b1011;
    step();
    chk("fair_next_3", 32'(gnt), 32'h8);
    wait_new_grant(g);
    chk("fair_next_0", 32'(g), 32'h1);
    wait_new_grant(g);
    chk("fair_next_1", 32'(g), 32'h2);
    req = '0;
    repeat (6) step();

    // Async reset mid-burst.
    req = 4'b0100;
    step();
    chk("mid_grant", 32'(gnt), 32'h4);
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_y", 32'(y), 32'h0);
    chk("async_yv", 32'(y_valid), 32'h0);
    step();
    rst = 1'b0;
    req = 4'b0101;
    step();
    chk("after_reset_ptr", 32'(gnt), 32'h1);
    req = '0;
    repeat (6) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      din = {$urandom, $urandom} & {(N*W){1'b1}};
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      step();
    end
    req = '0;
    repeat (8) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
